// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: mode constants and the
// pure next-value/boundary-hit function used by the counter register.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Fixed internal arithmetic width; wide enough for WIDTH+1 bits up to WIDTH=32.
  localparam int CALC_W = 33;

  typedef struct packed {
    logic [CALC_W-1:0] value;
    logic              hit;
  } next_t;

  function automatic next_t next_count(
    input logic [CALC_W-1:0] cur,
    input logic              up_dn,
    input logic [CALC_W-1:0] modulus,
    input logic              saturate
  );
    next_t             r;
    logic [CALC_W-1:0] top;
    top     = modulus - CALC_W'(1);
    r.value = cur;
    r.hit   = 1'b0;
    if (up_dn) begin
      if (cur == top) begin
        r.hit   = 1'b1;
        r.value = saturate ? top : '0;
      end else begin
        r.value = cur + CALC_W'(1);
      end
    end else begin
      if (cur == '0) begin
        r.hit   = 1'b1;
        r.value = saturate ? '0 : top;
      end else begin
        r.value = cur - CALC_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_updown_counter.sv
// Parametrised modulo-N up/down counter with clear, clamped load, wrap or
// saturate mode, terminal count, one-cycle boundary pulse and sticky overflow.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             ovf_sticky
);

  localparam logic [CALC_W-1:0] MOD_EXT  = CALC_W'(MODULUS);
  localparam logic [CALC_W-1:0] TOP_EXT  = MOD_EXT - CALC_W'(1);
  localparam logic [WIDTH-1:0]  TOP_W    = TOP_EXT[WIDTH-1:0];
  localparam logic              SAT_MODE = (SATURATE == MODE_SAT);

  logic [CALC_W-1:0] cur_ext;
  logic [CALC_W-1:0] lv_ext;
  next_t             nc;
  logic [WIDTH-1:0]  step_val;
  logic [WIDTH-1:0]  load_clamped;

  always_comb begin
    cur_ext      = CALC_W'(count_out);
    lv_ext       = CALC_W'(load_val);
    nc           = next_count(cur_ext, up_dn, MOD_EXT, SAT_MODE);
    // Out-of-range results cannot occur; fold the upper bits into a clamp anyway.
    step_val     = (|nc.value[CALC_W-1:WIDTH]) ? TOP_W : nc.value[WIDTH-1:0];
    load_clamped = (lv_ext > TOP_EXT) ? TOP_W : load_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      count_out  <= load_clamped;
      wrap_pulse <= 1'b0;
    end else if (en) begin
      count_out  <= step_val;
      wrap_pulse <= nc.hit;
      if (nc.hit) ovf_sticky <= 1'b1;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

  assign tc = up_dn ? (count_out == TOP_W) : (count_out == '0);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: four configurations share one input set and
// are compared every cycle against an arithmetic reference model.
module tb_sync_updown_counter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [2:0] cnt0, cnt1, cnt3;
  logic [3:0] cnt2;
  logic [N-1:0] tc_v, wp_v, ovf_v;

  int errors = 0;
  int checks = 0;

  int  m_cnt [N];
  bit  m_wp  [N];
  bit  m_ovf [N];

  typedef struct {
    logic       clr, load, en, up;
    logic [3:0] lv;
    int         cnt;
    logic       tc, wp, ovf;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv[2:0]), .count_out(cnt0), .tc(tc_v[0]), .wrap_pulse(wp_v[0]),
    .ovf_sticky(ovf_v[0]));

  sync_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv[2:0]), .count_out(cnt1), .tc(tc_v[1]), .wrap_pulse(wp_v[1]),
    .ovf_sticky(ovf_v[1]));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv), .count_out(cnt2), .tc(tc_v[2]), .wrap_pulse(wp_v[2]),
    .ovf_sticky(ovf_v[2]));

  sync_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1)) dut_d (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv[2:0]), .count_out(cnt3), .tc(tc_v[3]), .wrap_pulse(wp_v[3]),
    .ovf_sticky(ovf_v[3]));

  function automatic int mod_of(input int i);
    case (i)
      0: return 6;
      1: return 6;
      2: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic bit sat_of(input int i);
    return (i == 1) || (i == 3);
  endfunction

  function automatic int wid_of(input int i);
    return (i == 2) ? 4 : 3;
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_wp[i]  = 1'b0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // Reference: plain integer arithmetic, out-of-range results become a boundary hit.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int m, c, n;
      m = mod_of(i);
      if (clr) begin
        m_cnt[i] = 0; m_wp[i] = 1'b0; m_ovf[i] = 1'b0;
      end else if (load) begin
        c = int'(lv) % (1 << wid_of(i));
        m_cnt[i] = (c > m - 1) ? m - 1 : c;
        m_wp[i]  = 1'b0;
      end else if (en) begin
        n = up_dn ? m_cnt[i] + 1 : m_cnt[i] - 1;
        if (n < 0 || n >= m) begin
          m_wp[i]  = 1'b1;
          m_ovf[i] = 1'b1;
          n = sat_of(i) ? m_cnt[i] : (n + m) % m;
        end else begin
          m_wp[i] = 1'b0;
        end
        m_cnt[i] = n;
      end else begin
        m_wp[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      int  m;
      bit  exp_tc;
      m      = mod_of(i);
      exp_tc = (up_dn && m_cnt[i] == m - 1) || (!up_dn && m_cnt[i] == 0);
      chk($sformatf("%s.cnt%0d", tag, i), dut_cnt(i), m_cnt[i]);
      chk($sformatf("%s.tc%0d", tag, i), int'(tc_v[i]), int'(exp_tc));
      chk($sformatf("%s.wp%0d", tag, i), int'(wp_v[i]), int'(m_wp[i]));
      chk($sformatf("%s.ovf%0d", tag, i), int'(ovf_v[i]), int'(m_ovf[i]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic c, l, e, u, input int v, input int cnt,
                              input logic t, w, o);
    vec_t r;
    r.clr = c; r.load = l; r.en = e; r.up = u; r.lv = 4'(v);
    r.cnt = cnt; r.tc = t; r.wp = w; r.ovf = o;
    return r;
  endfunction

  initial begin
    int sat_cnt [7];
    bit sat_wp  [7];
    sat_cnt = '{1, 2, 3, 4, 5, 5, 5};
    sat_wp  = '{0, 0, 0, 0, 0, 1, 1};

    // Directed vectors for the M=6 wrap counter: clr, load, en, up, lv -> cnt, tc, wp, ovf
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 0, 1, 1, 0, k % 6, (k == 5), (k == 6), (k >= 6)));
    tbl.push_back(mk(0, 1, 0, 0, 2, 2, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 5, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 7, 5, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    foreach (tbl[k]) begin
      clr = tbl[k].clr; load = tbl[k].load; en = tbl[k].en;
      up_dn = tbl[k].up; lv = tbl[k].lv;
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("vec%0d.cnt", k), int'(cnt0), tbl[k].cnt);
      chk($sformatf("vec%0d.tc", k), int'(tc_v[0]), int'(tbl[k].tc));
      chk($sformatf("vec%0d.wp", k), int'(wp_v[0]), int'(tbl[k].wp));
      chk($sformatf("vec%0d.ovf", k), int'(ovf_v[0]), int'(tbl[k].ovf));
      check_all($sformatf("vec%0d", k));
    end
    clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1;

    // Saturating count-up: holds at 5 with a pulse on every enabled cycle there.
    async_reset_pulse();
    en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick($sformatf("sat%0d", k));
      chk($sformatf("sat%0d.cnt_b", k), int'(cnt1), sat_cnt[k]);
      chk($sformatf("sat%0d.wp_b", k), int'(wp_v[1]), int'(sat_wp[k]));
    end
    chk("sat.tc_b", int'(tc_v[1]), 1);
    chk("sat.ovf_b", int'(ovf_v[1]), 1);

    // Asynchronous reset mid-count, between clock edges.
    async_reset_pulse();
    for (int k = 0; k < 3; k++) tick($sformatf("pre%0d", k));
    chk("pre.cnt_a", int'(cnt0), 3);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst.cnt_a", int'(cnt0), 0);
    chk("arst.wp", int'(wp_v), 0);
    chk("arst.ovf", int'(ovf_v), 0);
    check_all("arst");
    #1 reset = 1'b1;
    tick("resume");
    chk("resume.cnt_a", int'(cnt0), 1);

    // Full-range wrap on the 4-bit counter with en toggling every cycle.
    async_reset_pulse();
    up_dn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      en = (k % 2 == 0);
      tick($sformatf("tog%0d", k));
    end
    chk("tog.cnt_c", int'(cnt2), 4);
    chk("tog.ovf_c", int'(ovf_v[2]), 1);

    // Randomized traffic against the model.
    async_reset_pulse();
    for (int k = 0; k < 400; k++) begin
      clr   = ($urandom_range(0, 24) == 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up_dn = (k % 64 < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      lv    = 4'($urandom_range(0, 15));
      tick($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
